// File: rtl/mult_pipe_nxn.sv
// rtl/mult_pipe_nxn.sv - pipelined NxN multiplier with per-operand signedness
// Sign-magnitude datapath: magnitudes, partial products, registered adder tree, sign apply.
module mult_pipe_nxn #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   n1,
  input  logic [WIDTH-1:0]   n2,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               result_zero
);

  localparam int L   = $clog2(WIDTH);
  localparam int LAT = L + 3;
  localparam int PW  = 2 * WIDTH;

  logic             adv;
  logic [LAT-1:0]   vld;
  logic [LAT-2:0]   sgn;
  logic [LAT-2:0]   zro;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    root;
  logic [PW-1:0]    res_q;
  logic             zero_q;
  logic             neg_a;
  logic             neg_b;
  logic             op_zero;

  assign adv         = out_ready | ~vld[LAT-1];
  assign in_ready    = adv;
  assign out_valid   = vld[LAT-1];
  assign result      = res_q;
  assign result_zero = zero_q;

  assign neg_a   = a_signed & n1[WIDTH-1];
  assign neg_b   = b_signed & n2[WIDTH-1];
  assign op_zero = (n1 == '0) | (n2 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[LAT-2:0], in_valid};
    end
  end

  // Sign and zero ride a shift line parallel to the data so each stays with its operands.
  always_ff @(posedge clk) begin
    if (adv) begin
      mag_a <= neg_a ? -n1 : n1;
      mag_b <= neg_b ? -n2 : n2;
      sgn   <= {sgn[LAT-3:0], (neg_a ^ neg_b) & ~op_zero};
      zro   <= {zro[LAT-3:0], op_zero};
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [PW-1:0] q;
    always_ff @(posedge clk) begin
      if (adv) q <= {{WIDTH{1'b0}}, mag_a & {WIDTH{mag_b[i]}}} << i;
    end
  end

  for (genvar j = 1; j <= L; j++) begin : g_lvl
    for (genvar i = 0; i < (WIDTH >> j); i++) begin : g_node
      logic [PW-1:0] q;
      if (j == 1) begin : g_first
        always_ff @(posedge clk) begin
          if (adv) q <= g_pp[2*i].q + g_pp[2*i+1].q;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (adv) q <= g_lvl[j-1].g_node[2*i].q + g_lvl[j-1].g_node[2*i+1].q;
        end
      end
    end
  end

  assign root = g_lvl[L].g_node[0].q;

  // Output register is reset and zeroed for empty slots so idle outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (adv) begin
      if (vld[LAT-2] && !zro[LAT-2]) res_q <= sgn[LAT-2] ? -root : root;
      else                           res_q <= '0;
      zero_q <= vld[LAT-2] & zro[LAT-2];
    end
  end

endmodule

// File: tb/tb_mult_pipe_nxn.sv
// tb/tb_mult_pipe_nxn.sv - self-checking bench for mult_pipe_nxn
module tb_mult_pipe_nxn;
  localparam int LAT   = 6;
  localparam int LAT16 = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, a_signed, b_signed, out_valid, out_ready, result_zero;
  logic [7:0]  n1, n2;
  logic [15:0] result;
  logic        in_valid16, in_ready16, a_s16, b_s16, out_valid16, out_ready16, zero16;
  logic [15:0] n1_16, n2_16;
  logic [31:0] result16;

  mult_pipe_nxn #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .n1(n1), .n2(n2), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_zero(result_zero)
  );

  mult_pipe_nxn #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .n1(n1_16), .n2(n2_16), .a_signed(a_s16), .b_signed(b_s16),
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16), .result_zero(zero16)
  );

  typedef struct {
    logic [15:0] res;
    logic        z;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_pop    = 0;
  bit          lat_chk;
  bit          accepted;
  logic        iv, as_, bs_, ordy;
  logic [7:0]  a_, b_;
  bit          ovr;
  logic [15:0] ovr_res;
  logic        ovr_z;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic as, input logic bs);
    longint x, y, p;
    x = as ? longint'($signed(a)) : longint'(a);
    y = bs ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, score the transfers due at the next posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    in_valid = iv; n1 = a_; n2 = b_; a_signed = as_; b_signed = bs_; out_ready = ordy;
    #1;
    cyc++;
    if (out_valid) begin
      if (out_ready) begin
        check("unexpected_out", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          n_pop++;
          check("result", result, e.res);
          check("result_zero", result_zero, e.z);
          if (lat_chk) check("latency", cyc - e.acc, LAT);
        end
      end
    end else begin
      check("idle_result", result, 0);
      check("idle_zero", result_zero, 0);
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      e.res = ovr ? ovr_res : model(n1, n2, a_signed, b_signed);
      e.z   = ovr ? ovr_z : ((n1 == 8'h00) || (n2 == 8'h00));
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    iv = 1'b0; ordy = 1'b1; ovr = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    check("drain_empty", q.size(), 0);
  endtask

  logic [7:0] edges [0:4] = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h01};
  logic [7:0] pa [0:9];
  logic [7:0] pb [0:9];

  initial begin
    int p;
    int n;
    logic [15:0] held;
    rst_n = 1'b0;
    in_valid = 0; n1 = 0; n2 = 0; a_signed = 0; b_signed = 0; out_ready = 1;
    in_valid16 = 0; n1_16 = 0; n2_16 = 0; a_s16 = 0; b_s16 = 0; out_ready16 = 1;
    iv = 0; a_ = 0; b_ = 0; as_ = 0; bs_ = 0; ordy = 1; ovr = 0; ovr_res = 0; ovr_z = 0;
    lat_chk = 1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", result_zero, 0);
    check("rst_out_valid16", out_valid16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", in_ready, 1);

    // -128 x -128
    iv = 1; a_ = 8'h80; b_ = 8'h80; as_ = 1; bs_ = 1; ovr = 1; ovr_res = 16'h4000; ovr_z = 0;
    step();
    drain();
    // 255 unsigned x -128 signed
    iv = 1; a_ = 8'hFF; b_ = 8'h80; as_ = 0; bs_ = 1; ovr = 1; ovr_res = 16'h8080; ovr_z = 0;
    step();
    drain();
    // 255 x 255 unsigned, then zero operand against a negative one
    iv = 1; a_ = 8'hFF; b_ = 8'hFF; as_ = 0; bs_ = 0; ovr = 1; ovr_res = 16'hFE01; ovr_z = 0;
    step();
    a_ = 8'h00; b_ = 8'h85; as_ = 1; bs_ = 1; ovr = 1; ovr_res = 16'h0000; ovr_z = 1;
    step();
    drain();

    // Ten back-to-back signed pairs with a three-cycle downstream stall
    lat_chk = 0;
    for (int i = 0; i < 10; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    p = 0; n_pop = 0; held = '0;
    as_ = 1; bs_ = 1;
    for (int k = 0; k < 40 && (p < 10 || q.size() != 0); k++) begin
      iv   = (p < 10);
      a_   = pa[p % 10];
      b_   = pb[p % 10];
      ordy = !(k >= 8 && k <= 10);
      step();
      check("in_ready_stall", in_ready, ordy);
      if (!ordy) begin
        check("stall_out_valid", out_valid, 1);
        if (k == 8) held = result;
        else        check("stall_hold", result, held);
      end
      if (accepted) p++;
    end
    check("stream_accepted", p, 10);
    check("stream_delivered", n_pop, 10);
    check("stream_empty", q.size(), 0);

    // Random operands, flags, bubbles and backpressure
    for (int k = 0; k < 80; k++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      as_  = 1'($urandom);
      bs_  = 1'($urandom);
      a_   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 8'($urandom);
      b_   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 8'($urandom);
      step();
    end
    drain();

    // Reset two cycles after acceptance drops the operation
    lat_chk = 1;
    iv = 1; a_ = 8'h12; b_ = 8'h34; as_ = 0; bs_ = 0; ordy = 1;
    step();
    iv = 0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("post_rst_idle", out_valid, 0);
    end
    iv = 1; a_ = 8'h9C; b_ = 8'h07; as_ = 1; bs_ = 0;
    step();
    drain();

    // WIDTH=16: -32768 x 32767
    @(negedge clk);
    in_valid16 = 1; n1_16 = 16'h8000; n2_16 = 16'h7FFF; a_s16 = 1; b_s16 = 1;
    #1;
    check("w16_in_ready", in_ready16, 1);
    @(negedge clk);
    in_valid16 = 0;
    #1;
    n = 1;
    while (!out_valid16 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("w16_latency", n, LAT16);
    check("w16_result", result16, 32'hC0008000);
    check("w16_zero", zero16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_pipe_nxn.md
MULT_PIPE_NXN -- requirements
Module: mult_pipe_nxn

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, power of two, range 4..32.
REQ-002 SHALL derive the internal constant LAT = log2(WIDTH) + 3, the cycles from input acceptance to output valid (6 at WIDTH=8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand pair is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-007 SHALL have port n1, input, WIDTH bits: operand A.
REQ-008 SHALL have port n2, input, WIDTH bits: operand B.
REQ-009 SHALL have port a_signed, input, 1 bit: 1 = n1 is two's complement, 0 = unsigned.
REQ-010 SHALL have port b_signed, input, 1 bit: 1 = n2 is two's complement, 0 = unsigned.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port result, output, 2*WIDTH bits: the product.
REQ-014 SHALL have port result_zero, output, 1 bit: 1 when either operand was zero.

Function
REQ-015 SHALL accept a transfer when in_valid and in_ready are both high; a transfer completes when out_valid and out_ready are both high.
REQ-016 SHALL use a global advance enable adv = out_ready OR NOT out_valid; in_ready SHALL equal adv (combinational); all pipeline registers, data and valid, SHALL hold their value when adv = 0.
REQ-017 SHALL present result LAT cycles after acceptance when out_ready is held high; back-to-back acceptance SHALL sustain one result per cycle.
REQ-018 SHALL register in stage 1: operand magnitudes (negated only when the operand's signed flag is 1 and its MSB is 1), product sign = XOR of the effective operand signs, and the zero flag.
REQ-019 SHALL hold magnitudes as WIDTH-bit unsigned values, so the magnitude of the most negative value (0x80 at WIDTH=8) is 128 with no overflow.
REQ-020 SHALL register in stage 2 the WIDTH partial products (magnitude A AND bit i of magnitude B), each shifted left by i.
REQ-021 SHALL sum the partial products in a binary adder tree, one registered level per pairing, log2(WIDTH) levels, with no truncation of carries; the tree output is 2*WIDTH bits.
REQ-022 SHALL apply the sign in the final stage: result = two's complement of the magnitude when the sign is 1, else the magnitude.
REQ-023 SHALL force result to 0 and the sign to 0 when the zero flag is set, so that no negative zero is produced.
REQ-024 SHALL interpret result as two's complement when a_signed OR b_signed, else as unsigned; all operand combinations SHALL fit exactly in 2*WIDTH bits.
REQ-025 SHALL carry the sign, zero flag and valid bit alongside the data through every stage so that each stays aligned with its own operands.
REQ-026 SHALL treat a bubble (in_valid = 0 while adv = 1) as advancing an invalid slot; data registers in invalid slots are don't-care, but result and result_zero SHALL be 0 whenever out_valid = 0.
REQ-027 SHALL keep result, result_zero and out_valid stable while out_valid = 1 and out_ready = 0.

Reset
REQ-028 SHALL clear all valid bits asynchronously when rst_n = 0; out_valid, result and result_zero SHALL read 0 during reset.
REQ-029 SHALL drop any in-flight operation on reset mid-operation; no result SHALL emerge for it after release.
REQ-030 SHALL drive in_ready = 1 from the first clock after rst_n deasserts.

Verification
REQ-031 SHALL verify, at WIDTH=8 with both signed flags 1 and out_ready held 1: n1 = 0x80 (-128), n2 = 0x80 -> result 0x4000 exactly 6 cycles later, result_zero = 0.
REQ-032 SHALL verify, at WIDTH=8 with a_signed = 0 and b_signed = 1: n1 = 0xFF (255), n2 = 0x80 (-128) -> result 0x8080 (-32640).
REQ-033 SHALL verify, at WIDTH=8 unsigned: 0xFF x 0xFF -> result 0xFE01; then n1 = 0x00, n2 = 0x85 signed -> result 0x0000, result_zero = 1.
REQ-034 SHALL verify 10 back-to-back signed pairs, with out_ready deasserted for 3 cycles mid-stream -> in_ready low for exactly those cycles, no loss, no duplication, results in order.
REQ-035 SHALL verify rst_n pulsed low 2 cycles after acceptance -> out_valid stays 0 until a new pair is accepted.
REQ-036 SHALL verify, at WIDTH=16: 0x8000 x 0x7FFF signed -> result 0xC0008000 after 7 cycles.
